// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two WORDS*6-bit operands by time-sharing one
// 6-bit prefix adder, one slice per clock, least-significant slice first.
// Optional feature macro: WIDE_ADD_SUB_EN adds a 'sub' input that turns the
// operation into A-B (b inverted, carry-in forced to 1).

// 6-bit Kogge-Stone adder; carry-in folded into bit 0 generate.
module prefix_adder (
    input  logic [5:0] i_x,
    input  logic [5:0] i_y,
    input  logic       i_c,
    output logic [5:0] o_s,
    output logic       o_c
);
    // w_g[k][i]: group generate over bits [i-2^k+1 .. i] (plus carry-in once the span reaches bit 0)
    logic [3:0][5:0] w_g;
    logic [2:0][5:0] w_p;

    assign w_p[0] = i_x ^ i_y;
    assign w_g[0] = (i_x & i_y) | {5'b0, w_p[0][0] & i_c};

    for (genvar k = 0; k < 3; k++) begin : g_lvl
        localparam int D = 1 << k;
        for (genvar i = 0; i < 6; i++) begin : g_bit
            if (i >= D) begin : g_comb
                assign w_g[k+1][i] = w_g[k][i] | (w_p[k][i] & w_g[k][i-D]);
            end else begin : g_pass
                assign w_g[k+1][i] = w_g[k][i];
            end
            // The final level needs only generates, so propagates stop at level 2.
            if (k < 2) begin : g_prop
                if (i >= D) begin : g_pc
                    assign w_p[k+1][i] = w_p[k][i] & w_p[k][i-D];
                end else begin : g_pp
                    assign w_p[k+1][i] = w_p[k][i];
                end
            end
        end
    end

    assign o_s = w_p[0] ^ {w_g[3][4:0], i_c};
    assign o_c = w_g[3][5];
endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6*WORDS-1:0] a,
    input  logic [6*WORDS-1:0] b,
    input  logic               c_in,
`ifdef WIDE_ADD_SUB_EN
    input  logic               sub,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6*WORDS-1:0] sum,
    output logic               c_out,
    output logic               busy
);
    localparam int W    = 6 * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          r_state;
    logic [W-1:0]    r_a, r_b, r_sum;
    logic            r_carry, r_cout;
    logic [IDXW-1:0] r_idx;
    logic            r_in_ready, r_out_valid, r_busy;

    logic [W-1:0]    w_b_in;
    logic            w_c_in;
    logic [5:0]      w_x, w_y, w_s;
    logic            w_co;

`ifdef WIDE_ADD_SUB_EN
    // Subtract as A + ~B + 1; c_in is not used in that mode.
    assign w_b_in = sub ? ~b : b;
    assign w_c_in = sub ? 1'b1 : c_in;
`else
    assign w_b_in = b;
    assign w_c_in = c_in;
`endif

    assign w_x = r_a[6*r_idx +: 6];
    assign w_y = r_b[6*r_idx +: 6];

    prefix_adder u_add (
        .i_x (w_x),
        .i_y (w_y),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    // Control FSM with datapath registers; handshake outputs are registered alongside state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= w_b_in;
                        r_carry    <= w_c_in;
                        r_idx      <= '0;
                        r_state    <= S_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_sum[6*r_idx +: 6] <= w_s;
                    r_carry             <= w_co;
                    if (r_idx == LAST) begin
                        r_cout      <= w_co;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sum       = r_sum;
    assign c_out     = r_cout;
endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that time-shares one 6-bit prefix_adder instance to add operands of WORDS×6 bits.
- Works least-significant slice first, one 6-bit slice per clock, and registers the carry between slices.
- Accepts operands through a valid/ready input handshake and returns sum plus carry-out through a valid/ready output handshake.
- Sits between operand producers and the result consumer wherever adds wider than 6 bits are needed.

Parameters:
- WORDS, 4, number of 6-bit slices per operand (legal range 1..16); operand width W = 6*WORDS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and c_in valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- c_in  input  1  carry into slice 0.
- out_valid  output  1  sum and c_out valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  A + B + c_in, modulo 2^W.
- c_out  output  1  carry out of the top slice.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Internal instance: one prefix_adder.
  - Its X/Y inputs are the current 6-bit slices of the latched A/B.
  - Its c_in is the carry register.
  - Only this instance performs arithmetic.
- Registers:
  - a_q, b_q (W bits).
  - carry_q.
  - sum_q (W bits).
  - cout_q.
  - slice counter idx, $clog2(WORDS) bits, minimum 1 bit.
  - state.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_q<=a, b_q<=b, carry_q<=c_in, idx<=0; go to RUN.
  - a, b and c_in are ignored at all other times.
- RUN:
  - in_ready=0.
  - Each cycle, the adder sees a_q[6*idx+:6], b_q[6*idx+:6] and carry_q.
  - At the clock edge: sum_q[6*idx+:6]<=S, carry_q<=adder c_out.
  - If idx==WORDS-1: cout_q<=adder c_out and go to DONE. Otherwise idx<=idx+1.
  - out_ready is ignored while in RUN.
- DONE:
  - out_valid=1; sum=sum_q, c_out=cout_q, both held stable while out_valid=1.
  - On out_ready: go to IDLE.
  - in_ready=0 in DONE; no same-cycle re-accept.
- Latency:
  - Input handshake at edge E; out_valid is high after edge E+WORDS.
  - Minimum initiation interval is WORDS+2 cycles: accept, WORDS run cycles, and one DONE cycle with out_ready=1.
- WORDS=1: RUN lasts exactly one cycle; idx stays 0.
- Outputs are registered or derived from state only. There is no combinational path from in_valid/out_ready to any output.
- Reset (asynchronous, any state, including mid-RUN or in DONE):
  - state=IDLE.
  - in_ready=1 after reset release.
  - out_valid=0, busy=0.
  - sum=0, c_out=0.
  - All registers cleared.
  - An in-flight operation is discarded with no partial result.
- sum and c_out outside DONE hold the last completed result, or 0 after reset. Consumers must qualify them with out_valid.

Optional Feature:
- Macro: WIDE_ADD_SUB_EN.
- Defined:
  - Adds port `sub  input  1`, sampled with the input handshake.
  - When sub=1: b_q<=~b and carry_q<=1, so the block computes A−B; c_in is ignored, and c_out=1 means no borrow (A≥B unsigned).
  - When sub=0: behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Test Plan:
- WORDS=4, a=0xFFFFFF, b=0x000001, c_in=0 -> out_valid exactly 4 cycles after the accept edge, sum=0x000000, c_out=1 (carry ripples through all slices).
- WORDS=4, a=0x123456, b=0x0ABCDE, c_in=1, out_ready held low 10 cycles -> sum=0x1CF135, c_out=0, stable for the whole stall; in_ready=0 and in_valid ignored throughout; one-cycle out_ready returns to IDLE.
- Back-to-back ops with in_valid and out_ready tied high, random operands -> every result matches the model; handshakes spaced exactly WORDS+2 cycles apart.
- rst_n pulsed low during RUN at idx=2 -> out_valid never asserts for that op; after release in_ready=1, sum=0, and the next op (0x000003+0x000004) gives 0x000007.
- WORDS=1, a=0x3F, b=0x3F, c_in=1 -> sum=0x3F, c_out=1, out_valid 1 cycle after accept.
- WIDE_ADD_SUB_EN defined, WORDS=4: sub=1, a=0x000010, b=0x000001 -> sum=0x00000F, c_out=1; then sub=1, a=0, b=1 -> sum=0xFFFFFF, c_out=0.
